pixel_stream_processor: RTL and testbench



---
 rtl/pixel_stream_processor.sv | 174 +++++++++++++++++
 tb/tb_pixel_stream_processor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_processor.sv
// Streaming RGB pixel processor: gathers words into groups, applies a per-pixel
// function on transfer to a second buffer, then drains that buffer word by word.
module pixel_stream_processor #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_SIZE  = 24,
  parameter int COLOR_SIZE  = 8,
  parameter int GROUP_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  in_last,
  input  logic [1:0]            mode,
  input  logic [COLOR_SIZE-1:0] proc_val,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  done
);
  localparam int GROUP_BITS = GROUP_WORDS * DATA_WIDTH;
  localparam int NPIX       = GROUP_BITS / PIXEL_SIZE;
  localparam int CW         = $clog2(GROUP_WORDS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(GROUP_WORDS - 1);
  localparam logic [COLOR_SIZE+1:0] THREE = (COLOR_SIZE + 2)'(3);

  function automatic logic [COLOR_SIZE-1:0] sat_add(input logic [COLOR_SIZE-1:0] c,
                                                    input logic [COLOR_SIZE-1:0] v);
    logic [COLOR_SIZE:0] s;
    s = {1'b0, c} + {1'b0, v};
    return s[COLOR_SIZE] ? '1 : s[COLOR_SIZE-1:0];
  endfunction

  function automatic logic [PIXEL_SIZE-1:0] proc_pixel(input logic [PIXEL_SIZE-1:0] p,
                                                       input logic [1:0] m,
                                                       input logic [COLOR_SIZE-1:0] v);
    logic [COLOR_SIZE+1:0] sum;
    logic [COLOR_SIZE+1:0] avg;
    logic [PIXEL_SIZE-1:0] r;
    r   = p;
    sum = '0;
    avg = '0;
    case (m)
      2'd1: begin
        for (int c = 0; c < 3; c++) sum = sum + {2'b00, p[c*COLOR_SIZE +: COLOR_SIZE]};
        avg = sum / THREE;
        r   = (avg > {2'b00, v}) ? '1 : '0;
      end
      2'd2: for (int c = 0; c < 3; c++)
              r[c*COLOR_SIZE +: COLOR_SIZE] = sat_add(p[c*COLOR_SIZE +: COLOR_SIZE], v);
      2'd3: r = ~p;
      default: r = p;
    endcase
    return r;
  endfunction

  // Only pixels wholly inside the received words are processed.
  function automatic logic [GROUP_BITS-1:0] proc_group(input logic [GROUP_BITS-1:0] g,
                                                       input logic [CW-1:0] n,
                                                       input logic [1:0] m,
                                                       input logic [COLOR_SIZE-1:0] v);
    logic [GROUP_BITS-1:0] r;
    r = g;
    for (int i = 0; i < NPIX; i++)
      if ((i + 1) * PIXEL_SIZE <= int'(n) * DATA_WIDTH)
        r[i*PIXEL_SIZE +: PIXEL_SIZE] = proc_pixel(g[i*PIXEL_SIZE +: PIXEL_SIZE], m, v);
    return r;
  endfunction

  logic [GROUP_BITS-1:0] coll_buf_q, coll_buf_d, out_buf_q, out_buf_d;
  logic [CW-1:0]         wcnt_q, wcnt_d, out_n_q, out_n_d, out_idx_q, out_idx_d;
  logic                  coll_closed_q, coll_closed_d, coll_last_q, coll_last_d;
  logic                  out_full_q, out_full_d, out_lgrp_q, out_lgrp_d;
  logic                  frame_act_q, frame_act_d, done_q, done_d;
  logic [1:0]            mode_q, mode_d;
  logic [COLOR_SIZE-1:0] pval_q, pval_d;
  logic                  acc, out_hs, out_emptying, do_xfer;

  assign in_rdy   = !rst && !coll_closed_q;
  assign out_vld  = out_full_q;
  assign data_out = out_buf_q[out_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign out_last = out_full_q && out_lgrp_q && (out_idx_q == out_n_q - CW'(1));
  assign done     = done_q;

  always_comb begin
    coll_buf_d    = coll_buf_q;
    out_buf_d     = out_buf_q;
    wcnt_d        = wcnt_q;
    out_n_d       = out_n_q;
    out_idx_d     = out_idx_q;
    coll_closed_d = coll_closed_q;
    coll_last_d   = coll_last_q;
    out_full_d    = out_full_q;
    out_lgrp_d    = out_lgrp_q;
    frame_act_d   = frame_act_q;
    mode_d        = mode_q;
    pval_d        = pval_q;
    acc           = in_vld && in_rdy;
    out_hs        = out_vld && out_rdy;
    out_emptying  = out_hs && (out_idx_q == out_n_q - CW'(1));
    done_d        = out_hs && out_last;

    // The first word of a frame samples the processing controls.
    if (acc) begin
      coll_buf_d[wcnt_q*DATA_WIDTH +: DATA_WIDTH] = data_in;
      wcnt_d      = wcnt_q + CW'(1);
      frame_act_d = !in_last;
      if (!frame_act_q) begin
        mode_d = mode;
        pval_d = proc_val;
      end
      if (wcnt_q == LAST_SLOT || in_last) begin
        coll_closed_d = 1'b1;
        coll_last_d   = in_last;
      end
    end

    if (out_hs) begin
      if (out_emptying) begin
        out_full_d = 1'b0;
        out_idx_d  = '0;
      end else begin
        out_idx_d = out_idx_q + CW'(1);
      end
    end

    // A group closing this cycle can bypass straight into a free output buffer.
    do_xfer = coll_closed_d && (!out_full_q || out_emptying);
    if (do_xfer) begin
      out_buf_d     = proc_group(coll_buf_d, wcnt_d, mode_d, pval_d);
      out_full_d    = 1'b1;
      out_idx_d     = '0;
      out_n_d       = wcnt_d;
      out_lgrp_d    = coll_last_d;
      coll_closed_d = 1'b0;
      coll_last_d   = 1'b0;
      wcnt_d        = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_buf_q    <= '0;
      out_buf_q     <= '0;
      wcnt_q        <= '0;
      out_n_q       <= '0;
      out_idx_q     <= '0;
      coll_closed_q <= 1'b0;
      coll_last_q   <= 1'b0;
      out_full_q    <= 1'b0;
      out_lgrp_q    <= 1'b0;
      frame_act_q   <= 1'b0;
      done_q        <= 1'b0;
      mode_q        <= '0;
      pval_q        <= '0;
    end else begin
      coll_buf_q    <= coll_buf_d;
      out_buf_q     <= out_buf_d;
      wcnt_q        <= wcnt_d;
      out_n_q       <= out_n_d;
      out_idx_q     <= out_idx_d;
      coll_closed_q <= coll_closed_d;
      coll_last_q   <= coll_last_d;
      out_full_q    <= out_full_d;
      out_lgrp_q    <= out_lgrp_d;
      frame_act_q   <= frame_act_d;
      done_q        <= done_d;
      mode_q        <= mode_d;
      pval_q        <= pval_d;
    end
  end
endmodule

// File: tb/tb_pixel_stream_processor.sv
// Scoreboard bench for pixel_stream_processor: 32-bit and 64-bit instances checked
// against a frame-level reference model of the pixel functions.
module tb_pixel_stream_processor;
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  logic        in_vld32, in_rdy32, in_last32, out_vld32, out_rdy32, out_last32, done32;
  logic [1:0]  mode32;
  logic [7:0]  pval32;
  logic [31:0] data_in32, data_out32;
  logic        in_vld64, in_rdy64, in_last64, out_vld64, out_rdy64, out_last64, done64;
  logic [1:0]  mode64;
  logic [7:0]  pval64;
  logic [63:0] data_in64, data_out64;

  pixel_stream_processor #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_vld(in_vld32), .in_rdy(in_rdy32), .in_last(in_last32),
    .mode(mode32), .proc_val(pval32), .data_in(data_in32), .data_out(data_out32),
    .out_vld(out_vld32), .out_rdy(out_rdy32), .out_last(out_last32), .done(done32));

  pixel_stream_processor #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_vld(in_vld64), .in_rdy(in_rdy64), .in_last(in_last64),
    .mode(mode64), .proc_val(pval64), .data_in(data_in64), .data_out(data_out64),
    .out_vld(out_vld64), .out_rdy(out_rdy64), .out_last(out_last64), .done(done64));

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  int stalls64 = 0;
  bit auto_push = 1'b1;
  logic [128:0] exp0[$];
  logic [128:0] exp1[$];
  logic [383:0] grp[2];
  int  gcnt[2];
  bit  fr_act[2];
  int  fmode[2];
  int  fpv[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: pixel functions computed from colour values with integer arithmetic.
  function automatic logic [383:0] model_group(input logic [383:0] g, input int nw, input int dw,
                                               input int md, input int pv);
    logic [383:0] r;
    int col, avg, px;
    r = g;
    for (int i = 0; i < (3 * dw) / 24; i++) begin
      px = i * 24;
      if ((i + 1) * 24 <= nw * dw) begin
        if (md == 1) begin
          avg = (int'(g[px +: 8]) + int'(g[px+8 +: 8]) + int'(g[px+16 +: 8])) / 3;
          for (int b = 0; b < 24; b++) r[px+b] = (avg > pv);
        end else if (md == 2 || md == 3) begin
          for (int c = 0; c < 3; c++) begin
            col = (md == 2) ? int'(g[px+8*c +: 8]) + pv : 255 - int'(g[px+8*c +: 8]);
            if (col > 255) col = 255;
            r[px+8*c +: 8] = 8'(col);
          end
        end
      end
    end
    return r;
  endfunction

  task automatic model_accept(input int id, input int dw, input logic [127:0] d, input logic l,
                              input int md, input int pv);
    logic [383:0] res;
    logic [127:0] m, w;
    if (!fr_act[id]) begin
      fmode[id] = md;
      fpv[id] = pv;
      fr_act[id] = 1'b1;
    end
    for (int b = 0; b < dw; b++) grp[id][gcnt[id]*dw + b] = d[b];
    gcnt[id]++;
    if (gcnt[id] == 3 || l) begin
      res = model_group(grp[id], gcnt[id], dw, fmode[id], fpv[id]);
      m = '1;
      m = m >> (128 - dw);
      for (int k = 0; k < gcnt[id]; k++) begin
        w = 128'(res >> (k * dw)) & m;
        if (auto_push) begin
          if (id == 0) exp0.push_back({(l && (k == gcnt[id] - 1)), w});
          else         exp1.push_back({(l && (k == gcnt[id] - 1)), w});
        end
      end
      gcnt[id] = 0;
      grp[id] = '0;
      if (l) fr_act[id] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      gcnt[id] = 0;
      grp[id] = '0;
      fr_act[id] = 1'b0;
    end
    exp0.delete();
    exp1.delete();
  endtask

  task automatic send32(input logic [31:0] d, input logic l, input logic [1:0] md, input logic [7:0] pv);
    int w = 0;
    @(negedge clk);
    in_vld32 = 1'b1; data_in32 = d; in_last32 = l; mode32 = md; pval32 = pv;
    while (!in_rdy32 && w < 100) begin @(negedge clk); w++; end
    if (!in_rdy32) begin
      total++; bad++;
      $display("FAIL in_rdy32_timeout: got 0 expected 1");
      in_vld32 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_vld32 = 1'b0;
    model_accept(0, 32, {96'b0, d}, l, int'(md), int'(pv));
  endtask

  task automatic send64(input logic [63:0] d, input logic l, input logic [1:0] md, input logic [7:0] pv);
    int w = 0;
    @(negedge clk);
    in_vld64 = 1'b1; data_in64 = d; in_last64 = l; mode64 = md; pval64 = pv;
    while (!in_rdy64 && w < 100) begin @(negedge clk); w++; stalls64++; end
    if (!in_rdy64) begin
      total++; bad++;
      $display("FAIL in_rdy64_timeout: got 0 expected 1");
      in_vld64 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_vld64 = 1'b0;
    model_accept(1, 64, {64'b0, d}, l, int'(md), int'(pv));
  endtask

  task automatic drain(input int id);
    int w = 0;
    while (((id == 0) ? exp0.size() : exp1.size()) != 0 && w < 500) begin @(negedge clk); w++; end
    if (((id == 0) ? exp0.size() : exp1.size()) != 0) begin
      total++; bad++;
      $display("FAIL drain%0d: %0d words outstanding, expected 0", id,
               (id == 0) ? exp0.size() : exp1.size());
      if (id == 0) exp0.delete(); else exp1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_rdy32 = 1'b1;
      1:       out_rdy32 = !out_rdy32;
      default: out_rdy32 = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor for the 32-bit instance.
  initial begin
    logic prev_l, stl;
    logic [31:0] pd;
    logic [128:0] e;
    prev_l = 1'b0; stl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_l = 1'b0; stl = 1'b0;
      end else begin
        if (prev_l || done32) chk("done32", {127'b0, done32}, {127'b0, prev_l});
        if (stl) begin
          chk("hold_vld32", {127'b0, out_vld32}, 128'd1);
          chk("hold_data32", {96'b0, data_out32}, {96'b0, pd});
        end
        if (out_vld32 && out_rdy32) begin
          if (exp0.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_word32: got %h expected no word", data_out32);
          end else begin
            e = exp0.pop_front();
            chk("data32", {96'b0, data_out32}, e[127:0]);
            chk("last32", {127'b0, out_last32}, {127'b0, e[128]});
          end
        end
        prev_l = out_vld32 && out_rdy32 && out_last32;
        stl = out_vld32 && !out_rdy32;
        pd = data_out32;
      end
    end
  end

  // Monitor for the 64-bit instance.
  initial begin
    logic prev_l;
    logic [128:0] e;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_l = 1'b0;
      else begin
        if (prev_l || done64) chk("done64", {127'b0, done64}, {127'b0, prev_l});
        if (out_vld64 && out_rdy64) begin
          if (exp1.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_word64: got %h expected no word", data_out64);
          end else begin
            e = exp1.pop_front();
            chk("data64", {64'b0, data_out64}, e[127:0]);
            chk("last64", {127'b0, out_last64}, {127'b0, e[128]});
          end
        end
        prev_l = out_vld64 && out_rdy64 && out_last64;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    logic [31:0] r32;
    rst = 1'b1;
    in_vld32 = 0; in_last32 = 0; mode32 = 0; pval32 = 0; data_in32 = 0; out_rdy32 = 1;
    in_vld64 = 0; in_last64 = 0; mode64 = 0; pval64 = 0; data_in64 = 0; out_rdy64 = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_rdy32", {127'b0, in_rdy32}, 128'd0);
    chk("rst_out_vld32", {127'b0, out_vld32}, 128'd0);
    chk("rst_data32", {96'b0, data_out32}, 128'd0);
    chk("rst_last32", {127'b0, out_last32}, 128'd0);
    chk("rst_done32", {127'b0, done32}, 128'd0);
    chk("rst_in_rdy64", {127'b0, in_rdy64}, 128'd0);
    rst = 1'b0;
    #1 chk("rdy_after_rst32", {127'b0, in_rdy32}, 128'd1);

    // Threshold group with fixed expected words.
    auto_push = 1'b0;
    exp0.push_back({1'b0, 128'h00FFFFFF});
    exp0.push_back({1'b0, 128'h00000000});
    exp0.push_back({1'b1, 128'hFFFFFF00});
    send32(32'h80909090, 1'b0, 2'd1, 8'h80);
    send32(32'h00FF8080, 1'b0, 2'd1, 8'h80);
    send32(32'h81818100, 1'b1, 2'd1, 8'h80);
    @(negedge clk);
    chk("latency32", {127'b0, out_vld32}, 128'd1);
    drain(0);

    // Single-word brightness frame with saturation and partial pixel.
    exp0.push_back({1'b1, 128'hF0FF3020});
    send32(32'hF0E01000, 1'b1, 2'd2, 8'h20);
    drain(0);

    // Invert under alternating backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) exp0.push_back({(i == 5), 128'hFFFFFFFF});
    for (int i = 0; i < 6; i++) send32(32'h0, (i == 5), 2'd3, 8'h00);
    drain(0);
    rdy_mode = 0;
    auto_push = 1'b1;

    // Mode changes mid-frame must be ignored; the next frame picks them up.
    send32($urandom, 1'b0, 2'd0, 8'h11);
    send32($urandom, 1'b0, 2'd3, 8'h11);
    send32($urandom, 1'b1, 2'd3, 8'h11);
    for (int i = 0; i < 3; i++) send32($urandom, (i == 2), 2'd3, 8'h11);
    drain(0);

    // Reset in the middle of a frame.
    send32($urandom, 1'b0, 2'd0, 8'h00);
    send32($urandom, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_vld32", {127'b0, out_vld32}, 128'd0);
    chk("midrst_data32", {96'b0, data_out32}, 128'd0);
    chk("midrst_done32", {127'b0, done32}, 128'd0);
    chk("midrst_in_rdy32", {127'b0, in_rdy32}, 128'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send32($urandom, (i == 2), 2'd0, 8'h00);
    drain(0);

    // Randomized frames, random backpressure and per-word mode noise.
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        r32 = $urandom;
        send32(r32, (i == len - 1), 2'($urandom_range(0, 3)), 8'($urandom));
      end
    end
    drain(0);
    rdy_mode = 0;

    // 64-bit instance: threshold on all-0x7F, then back-to-back random frame.
    auto_push = 1'b0;
    for (int i = 0; i < 3; i++) exp1.push_back({(i == 2), 128'h0000000000000000FFFFFFFFFFFFFFFF});
    for (int i = 0; i < 3; i++) send64(64'h7F7F7F7F7F7F7F7F, (i == 2), 2'd1, 8'h7E);
    auto_push = 1'b1;
    for (int i = 0; i < 6; i++) send64({$urandom, $urandom}, (i == 5), 2'd2, 8'h40);
    drain(1);
    chk("throughput64", 128'(stalls64), 128'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
